time_counter: RTL and testbench

Keeps the wall-clock time of day as four BCD digits (HH:MM, 24-hour). It sits directly downstream of the time generator and advances one minute on each `one_minute` strobe. It accepts a synchronous time-set load and raises a one-cycle flag at midnight. Its outputs feed the display driver and the alarm comparator.

---
 rtl/clock_pkg.sv | 9 +
 rtl/bcd_digit.sv | 23 ++
 rtl/time_counter.sv | 58 +++++
 tb/tb_time_counter.sv | 97 +++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// clock_pkg: shared BCD digit type and time-of-day digit limits
package clock_pkg;
  typedef logic [3:0] bcd_t;
  localparam bcd_t MIN_LS_MAX = 4'd9;
  localparam bcd_t MIN_MS_MAX = 4'd5;
  localparam bcd_t HR_MS_MAX = 4'd2;
  localparam bcd_t HR_LS_MAX_AT_20 = 4'd3;
  localparam bcd_t BCD_MAX = 4'd9;
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one decimal digit with enable, synchronous load, wrap limit and carry-out
module bcd_digit
  import clock_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic ld,
  input  bcd_t ld_val,
  input  bcd_t limit,
  output bcd_t q,
  output logic carry
);
  bcd_t q_q, q_d;
  logic wrap;
  assign wrap = q_q >= limit;
  assign carry = en & wrap;
  assign q = q_q;
  // load wins over increment; reaching the limit rolls back to zero
  always_comb q_d = ld ? ld_val : en ? (wrap ? 4'd0 : q_q + 4'd1) : q_q;
  // digit register
  always_ff @(posedge clk) q_q <= rst ? 4'd0 : q_d;
endmodule

// File: rtl/time_counter.sv
// time_counter: 24-hour HH:MM BCD clock with minute advance, validated time-set load and midnight flag
module time_counter
  import clock_pkg::*;
#(
  parameter int WRAP_HOURS = 24
) (
  input  logic clk256,
  input  logic reset,
  input  logic one_minute,
  input  logic load_new_time,
  input  bcd_t new_ms_hr,
  input  bcd_t new_ls_hr,
  input  bcd_t new_ms_min,
  input  bcd_t new_ls_min,
  output bcd_t ms_hr,
  output bcd_t ls_hr,
  output bcd_t ms_min,
  output bcd_t ls_min,
  output logic day_wrap,
  output logic load_error
);
  localparam bcd_t HR_LAST_MS = bcd_t'((WRAP_HOURS - 1) / 10);
  localparam bcd_t HR_LAST_LS = bcd_t'((WRAP_HOURS - 1) % 10);
  logic load_ok, ld, tick;
  logic c_ls_min, c_ms_min, c_ls_hr, c_ms_hr;
  logic day_wrap_q, load_error_q;
  bcd_t ls_hr_limit;
  assign load_ok = new_ls_min <= BCD_MAX && new_ms_min <= MIN_MS_MAX &&
                   new_ls_hr <= BCD_MAX && new_ms_hr <= HR_MS_MAX &&
                   (new_ms_hr != HR_MS_MAX || new_ls_hr <= HR_LS_MAX_AT_20);
  assign ld = load_new_time & load_ok;
  // a valid load swallows a coincident tick; a rejected one lets it through
  assign tick = one_minute & ~ld;
  assign ls_hr_limit = ms_hr == HR_LAST_MS ? HR_LAST_LS : BCD_MAX;
  assign day_wrap = day_wrap_q;
  assign load_error = load_error_q;
  bcd_digit u_ls_min (
    .clk(clk256), .rst(reset), .en(tick), .ld(ld), .ld_val(new_ls_min),
    .limit(MIN_LS_MAX), .q(ls_min), .carry(c_ls_min)
  );
  bcd_digit u_ms_min (
    .clk(clk256), .rst(reset), .en(c_ls_min), .ld(ld), .ld_val(new_ms_min),
    .limit(MIN_MS_MAX), .q(ms_min), .carry(c_ms_min)
  );
  bcd_digit u_ls_hr (
    .clk(clk256), .rst(reset), .en(c_ms_min), .ld(ld), .ld_val(new_ls_hr),
    .limit(ls_hr_limit), .q(ls_hr), .carry(c_ls_hr)
  );
  bcd_digit u_ms_hr (
    .clk(clk256), .rst(reset), .en(c_ls_hr), .ld(ld), .ld_val(new_ms_hr),
    .limit(HR_LAST_MS), .q(ms_hr), .carry(c_ms_hr)
  );
  // one-cycle flags: hour-tens carry is the midnight rollover, rejected loads raise an error
  always_ff @(posedge clk256) begin
    day_wrap_q <= reset ? 1'b0 : c_ms_hr;
    load_error_q <= reset ? 1'b0 : load_new_time & ~load_ok;
  end
endmodule

// File: tb/tb_time_counter.sv
// tb_time_counter: directed self-checking bench for time_counter
module tb_time_counter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic one_minute = 1'b0;
  logic load_new_time = 1'b0;
  logic [3:0] new_ms_hr = '0, new_ls_hr = '0, new_ms_min = '0, new_ls_min = '0;
  logic [3:0] ms_hr, ls_hr, ms_min, ls_min;
  logic day_wrap, load_error;
  int checks = 0;
  int errors = 0;
  logic [15:0] hhmm;
  assign hhmm = {ms_hr, ls_hr, ms_min, ls_min};
  always #5 clk = ~clk;
  time_counter dut (
    .clk256(clk), .reset(reset), .one_minute(one_minute), .load_new_time(load_new_time),
    .new_ms_hr(new_ms_hr), .new_ls_hr(new_ls_hr), .new_ms_min(new_ms_min), .new_ls_min(new_ls_min),
    .ms_hr(ms_hr), .ls_hr(ls_hr), .ms_min(ms_min), .ls_min(ls_min),
    .day_wrap(day_wrap), .load_error(load_error)
  );
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic t, input logic l, input logic [15:0] v);
    one_minute = t;
    load_new_time = l;
    {new_ms_hr, new_ls_hr, new_ms_min, new_ls_min} = v;
    @(negedge clk);
    one_minute = 1'b0;
    load_new_time = 1'b0;
  endtask
  task automatic expect_state(input string tag, input logic [15:0] t, input logic dw, input logic le);
    chk({tag, " time"}, hhmm, t);
    chk({tag, " day_wrap"}, {15'd0, day_wrap}, {15'd0, dw});
    chk({tag, " load_error"}, {15'd0, load_error}, {15'd0, le});
  endtask
  initial begin
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    expect_state("reset", 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 16'h0000);
      expect_state("idle", 16'h0000, 1'b0, 1'b0);
    end
    for (int i = 0; i < 9; i++) drive(1'b1, 1'b0, 16'h0000);
    expect_state("tick9", 16'h0009, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 16'h0000);
    expect_state("tick10", 16'h0010, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 16'h0959);
    expect_state("load0959", 16'h0959, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 16'h0000);
    expect_state("0959+1", 16'h1000, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 16'h1959);
    drive(1'b1, 1'b0, 16'h0000);
    expect_state("1959+1", 16'h2000, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 16'h2359);
    expect_state("load2359", 16'h2359, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 16'h0000);
    expect_state("midnight", 16'h0000, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 16'h0000);
    expect_state("after midnight", 16'h0000, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 16'h0000);
    expect_state("0000+1", 16'h0001, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 16'h2400);
    expect_state("bad2400", 16'h0001, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 16'h0000);
    expect_state("bad2400 end", 16'h0001, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 16'h1260);
    expect_state("bad1260", 16'h0001, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 16'h0000);
    expect_state("bad1260 end", 16'h0001, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 16'h1A00);
    expect_state("bad1A00", 16'h0001, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 16'h0000);
    expect_state("bad1A00 end", 16'h0001, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 16'h1234);
    expect_state("load+tick", 16'h1234, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 16'h2500);
    expect_state("bad+tick", 16'h1235, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 16'h0000);
    expect_state("held tick", 16'h1238, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 16'h2359);
    reset = 1'b1;
    drive(1'b1, 1'b0, 16'h0000);
    reset = 1'b0;
    expect_state("reset+tick", 16'h0000, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 16'h0000);
    expect_state("post reset tick", 16'h0001, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
